// File: rtl/btn_stepper_if.sv
// btn_stepper_if -- bundle of the pushbutton-stepper signals.
//
// Signals:
//   raw_d, raw_r : asynchronous, bouncing "down" / "right" pushbuttons
//   hold         : step inhibit from the consumer
//   btnD, btnR   : registered one-cycle step pulses
//   lvl          : debounced levels {R,D}
//
// Signalling: there is no valid/ready pair. A step is a single-cycle
// high on btnD/btnR that the consumer must take on that cycle; it cannot
// be back-pressured. hold=1 suppresses new steps instead of delaying them.
//
// Modports:
//   slave  : the stepper itself (takes buttons/hold, drives steps/levels)
//   master : the surrounding logic (drives buttons/hold, takes steps/levels)
interface btn_stepper_if;
    logic       raw_d;
    logic       raw_r;
    logic       hold;
    logic       btnD;
    logic       btnR;
    logic [1:0] lvl;

    modport master (output raw_d, raw_r, hold, input btnD, btnR, lvl);
    modport slave  (input raw_d, raw_r, hold, output btnD, btnR, lvl);
endinterface

// File: rtl/btn_stepper.sv
// btn_stepper -- debounces two pushbuttons and turns each accepted press
// into a one-cycle step pulse, with optional auto-repeat while held.
//
// Parameters:
//   DEB_CYC  : consecutive stable cycles to accept a new level (>= 2)
//   REP_DLY  : cycles from first step to first repeat step (>= 2)
//   REP_RATE : cycles between repeat steps (>= 2)
//
// Ports:
//   clk : system clock, rising edge
//   clr : synchronous active-high reset, dominates all other inputs
//   bus : btn_stepper_if.slave (raw_d, raw_r, hold in; btnD, btnR, lvl out)
//
// Configuration:
//   BTN_AUTO_REPEAT_EN defined   -> per-channel IDLE/FIRST/REPEAT repeat FSM
//   BTN_AUTO_REPEAT_EN undefined -> one pulse per accepted press; REP_DLY
//                                   and REP_RATE are unused
//
// Channel 0 is D, channel 1 is R; both are identical and independent.
module btn_stepper #(
    parameter int DEB_CYC  = 250000,
    parameter int REP_DLY  = 25000000,
    parameter int REP_RATE = 5000000
) (
    input logic          clk,
    input logic          clr,
    btn_stepper_if.slave bus
);
    localparam int DW = $clog2(DEB_CYC);

`ifdef BTN_AUTO_REPEAT_EN
    localparam int RW_DLY  = $clog2(REP_DLY);
    localparam int RW_RATE = $clog2(REP_RATE);
    // One repeat counter serves both phases, so it is sized for the larger.
    localparam int RW = (RW_DLY > RW_RATE) ? RW_DLY : RW_RATE;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FIRST  = 2'd1,
        ST_REPEAT = 2'd2
    } rep_state_t;
`endif

    logic [1:0] raw;
    logic [1:0] deb;
    logic [1:0] pulse;

    assign raw = {bus.raw_r, bus.raw_d};

    for (genvar c = 0; c < 2; c++) begin : g_ch
        logic          s1;
        logic          s2;
        logic          deb_q;
        logic          pulse_q;
        logic [DW-1:0] dcnt;
        logic          rise;

        // deb is about to go 0->1 on this edge.
        assign rise = s2 & ~deb_q & (dcnt == DW'(DEB_CYC - 1));

        // Synchronizer and debouncer: deb follows s2 only after s2 has
        // disagreed with it on DEB_CYC consecutive edges.
        always_ff @(posedge clk) begin
            if (clr) begin
                s1    <= 1'b0;
                s2    <= 1'b0;
                deb_q <= 1'b0;
                dcnt  <= '0;
            end else begin
                s1 <= raw[c];
                s2 <= s1;
                if (s2 == deb_q) begin
                    dcnt <= '0;
                end else if (dcnt == DW'(DEB_CYC - 1)) begin
                    deb_q <= s2;
                    dcnt  <= '0;
                end else begin
                    dcnt <= dcnt + 1'b1;
                end
            end
        end

`ifdef BTN_AUTO_REPEAT_EN
        logic          armed;
        logic          live;
        logic [RW-1:0] rcnt;
        rep_state_t    state;

        // Repeating continues only while the press that started it is still
        // held and un-inhibited; hold takes effect on the edge it is seen.
        assign live = armed & ~bus.hold & deb_q;

        always_ff @(posedge clk) begin
            if (clr) begin
                armed   <= 1'b0;
                rcnt    <= '0;
                state   <= ST_IDLE;
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= 1'b0;
                if (rise && !bus.hold) begin
                    pulse_q <= 1'b1;
                    armed   <= 1'b1;
                    rcnt    <= '0;
                    state   <= ST_FIRST;
                end else begin
                    if (!deb_q || bus.hold) begin
                        armed <= 1'b0;
                    end
                    if (!live) begin
                        state <= ST_IDLE;
                        rcnt  <= '0;
                    end else begin
                        case (state)
                            ST_FIRST: begin
                                if (rcnt == RW'(REP_DLY - 1)) begin
                                    pulse_q <= 1'b1;
                                    rcnt    <= '0;
                                    state   <= ST_REPEAT;
                                end else begin
                                    rcnt <= rcnt + 1'b1;
                                end
                            end
                            ST_REPEAT: begin
                                if (rcnt == RW'(REP_RATE - 1)) begin
                                    pulse_q <= 1'b1;
                                    rcnt    <= '0;
                                end else begin
                                    rcnt <= rcnt + 1'b1;
                                end
                            end
                            default: begin
                                state <= ST_IDLE;
                                rcnt  <= '0;
                            end
                        endcase
                    end
                end
            end
        end
`else
        // Single step per accepted press; a press accepted under hold is
        // simply lost, and releasing hold does not replay it.
        always_ff @(posedge clk) begin
            if (clr) begin
                pulse_q <= 1'b0;
            end else begin
                pulse_q <= rise & ~bus.hold;
            end
        end
`endif

        assign deb[c]   = deb_q;
        assign pulse[c] = pulse_q;
    end

    assign bus.btnD = pulse[0];
    assign bus.btnR = pulse[1];
    assign bus.lvl  = deb;
endmodule

// File: tb/tb_btn_stepper.sv
module tb_btn_stepper;
    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RR  = 3;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic clr;
    always #5 clk = ~clk;

    btn_stepper_if bif();

    btn_stepper #(
        .DEB_CYC (DEB),
        .REP_DLY (RD),
        .REP_RATE(RR)
    ) dut (
        .clk(clk),
        .clr(clr),
        .bus(bif)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc_n = 0;

    logic [31:0] exp_q[$];
    logic [31:0] got_q[$];

    // ---------------- reference model ----------------
    // Per channel: synchronizer pipe, the last DEB synchronized samples,
    // the accepted level, and the time since the current press was accepted.
    bit m_s1[2], m_s2[2], m_deb[2], m_armed[2], m_pulse[2];
    int m_t[2];
    bit m_hist[2][DEB];

    task automatic model_edge(input bit d, input bit r, input bit h, input bit c);
        bit rw[2];
        bit flip;
        rw[0] = d;
        rw[1] = r;
        for (int ch = 0; ch < 2; ch++) begin
            if (c) begin
                m_s1[ch] = 0; m_s2[ch] = 0; m_deb[ch] = 0;
                m_armed[ch] = 0; m_pulse[ch] = 0; m_t[ch] = 0;
                for (int k = 0; k < DEB; k++) m_hist[ch][k] = 0;
            end else begin
                for (int k = DEB - 1; k > 0; k--) m_hist[ch][k] = m_hist[ch][k-1];
                m_hist[ch][0] = m_s2[ch];
                // Level accepted once the last DEB samples all disagree with it.
                flip = 1;
                for (int k = 0; k < DEB; k++) if (m_hist[ch][k] == m_deb[ch]) flip = 0;
                m_pulse[ch] = 0;
`ifdef BTN_AUTO_REPEAT_EN
                if (flip && m_s2[ch] && !h) begin
                    m_pulse[ch] = 1;
                    m_t[ch]     = 0;
                    m_armed[ch] = 1;
                end else begin
                    if (m_armed[ch] && !h && m_deb[ch]) begin
                        m_t[ch]++;
                        if (m_t[ch] == RD || (m_t[ch] > RD && (m_t[ch] - RD) % RR == 0))
                            m_pulse[ch] = 1;
                    end
                    if (!m_deb[ch] || h) m_armed[ch] = 0;
                end
`else
                m_pulse[ch] = flip && m_s2[ch] && !h;
`endif
                if (flip) m_deb[ch] = m_s2[ch];
                m_s2[ch] = m_s1[ch];
                m_s1[ch] = rw[ch];
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc_n, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: apply inputs, advance the model on the edge, compare on
    // the falling edge.
    task automatic cyc(input bit d, input bit r, input bit h, input bit c);
        bif.raw_d = d;
        bif.raw_r = r;
        bif.hold  = h;
        clr       = c;
        @(posedge clk);
        model_edge(d, r, h, c);
        cyc_n++;
        @(negedge clk);
        check("model_btnD", 32'(bif.btnD), 32'(m_pulse[0]));
        check("model_btnR", 32'(bif.btnR), 32'(m_pulse[1]));
        check("model_lvl", 32'(bif.lvl), 32'({m_deb[1], m_deb[0]}));
    endtask

    // Run n cycles with fixed inputs, logging the index of each pulse on ch.
    task automatic record(input bit d, input bit r, input bit h, input int n, input int ch);
        for (int k = 0; k < n; k++) begin
            cyc(d, r, h, 1'b0);
            if ((ch == 0 && bif.btnD) || (ch == 1 && bif.btnR)) got_q.push_back(k);
        end
    endtask

    task automatic compare_q(input string name);
        check({name, "_count"}, got_q.size(), exp_q.size());
        while (exp_q.size() > 0 && got_q.size() > 0)
            check({name, "_offset"}, got_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        got_q.delete();
    endtask

    typedef struct {
        bit         d, r, h, c;
        bit         ed, er;
        logic [1:0] el;
    } vec_t;

    vec_t tbl[8];

    int  run_d, run_r, run_h;
    bit  rd, rr, rh, rc;

    initial begin
        // Clean raw_r rise first sampled at table row 0.
        tbl[0] = '{0, 1, 0, 0, 0, 0, 2'b00};
        tbl[1] = '{0, 1, 0, 0, 0, 0, 2'b00};
        tbl[2] = '{0, 1, 0, 0, 0, 0, 2'b00};
        tbl[3] = '{0, 1, 0, 0, 0, 0, 2'b00};
        tbl[4] = '{0, 1, 0, 0, 0, 0, 2'b00};
        tbl[5] = '{0, 1, 0, 0, 0, 1, 2'b10};
        tbl[6] = '{0, 1, 0, 0, 0, 0, 2'b10};
        tbl[7] = '{0, 1, 0, 0, 0, 0, 2'b10};

        bif.raw_d = 0; bif.raw_r = 0; bif.hold = 0; clr = 1;

        // Reset state
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
        check("reset_btnD", 32'(bif.btnD), 0);
        check("reset_btnR", 32'(bif.btnR), 0);
        check("reset_lvl", 32'(bif.lvl), 0);

        // Table-driven first press latency
        for (int i = 0; i < 8; i++) begin
            cyc(tbl[i].d, tbl[i].r, tbl[i].h, tbl[i].c);
            check("tbl_btnD", 32'(bif.btnD), 32'(tbl[i].ed));
            check("tbl_btnR", 32'(bif.btnR), 32'(tbl[i].er));
            check("tbl_lvl", 32'(bif.lvl), 32'(tbl[i].el));
        end
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
        check("release_lvl", 32'(bif.lvl), 0);

        // Bounce every 2 cycles never accepted
        for (int i = 0; i < 40; i++) begin
            cyc(bit'((i / 2) % 2), 0, 0, 0);
            check("bounce_btnD", 32'(bif.btnD), 0);
            check("bounce_lvl0", 32'(bif.lvl[0]), 0);
        end
        for (int i = 0; i < 10; i++) cyc(0, 0, 0, 0);

        // Long hold of raw_r: acceptance at index DEB+1, then repeats
        exp_q.push_back(DEB + 1);
`ifdef BTN_AUTO_REPEAT_EN
        for (int o = DEB + 1 + RD; o < 36; o += RR) exp_q.push_back(o);
`endif
        record(0, 1, 0, 36, 1);
        compare_q("hold_repeat");
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);

        // Press accepted under hold, hold released while still pressed
        record(1, 0, 1, 12, 0);
        check("hold_lvl0", 32'(bif.lvl[0]), 1);
        record(1, 0, 0, 15, 0);
        compare_q("hold_no_pulse");
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);
        exp_q.push_back(DEB + 1);
        record(1, 0, 0, 10, 0);
        compare_q("repress_pulse");
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);

        // clr for one cycle mid-repeat with raw_r held
        record(0, 1, 0, 20, 1);
        got_q.delete();
        cyc(0, 1, 0, 1);
        check("clr_btnR", 32'(bif.btnR), 0);
        check("clr_lvl", 32'(bif.lvl), 0);
        exp_q.push_back(DEB + 1);
`ifdef BTN_AUTO_REPEAT_EN
        for (int o = DEB + 1 + RD; o < 20; o += RR) exp_q.push_back(o);
`endif
        record(0, 1, 0, 20, 1);
        compare_q("clr_restart");
        for (int i = 0; i < 12; i++) cyc(0, 0, 0, 0);

        // Randomized stimulus against the model
        run_d = 0; run_r = 0; run_h = 0;
        rd = 0; rr = 0; rh = 0;
        for (int i = 0; i < 1500; i++) begin
            if (run_d == 0) begin rd = bit'($urandom_range(0, 1)); run_d = $urandom_range(1, 24); end
            if (run_r == 0) begin rr = bit'($urandom_range(0, 1)); run_r = $urandom_range(1, 24); end
            if (run_h == 0) begin rh = ($urandom_range(0, 3) == 0); run_h = $urandom_range(5, 60); end
            rc = ($urandom_range(0, 199) == 0);
            run_d--; run_r--; run_h--;
            cyc(rd, rr, rh, rc);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
